led_seg_encoder: RTL and testbench

Sequential reverse of the LED segment decoder. It samples an active-low 8-bit seven-segment bus, such as a decoder output or an external display driver tap. It filters glitches, then recovers the 5-bit display code {dp, hex digit}, with a one-cycle valid pulse per accepted pattern. It sits on the display loopback/self-check path so a bench or BIST can confirm what the panel is actually showing.

---
 rtl/led_seg_encoder_if.sv | 11 +
 rtl/led_seg_encoder.sv | 124 ++++++++++++
 tb/tb_led_seg_encoder.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/led_seg_encoder_if.sv
// Seven-segment loopback bus: raw active-low segment tap in, recovered display code out.
interface led_seg_encoder_if;
  logic [7:0] i_seg_n;
  logic [4:0] o_code;
  logic       o_valid;
  logic       o_err;
  logic       o_blank;

  modport master (output i_seg_n, input o_code, o_valid, o_err, o_blank);
  modport slave  (input i_seg_n, output o_code, o_valid, o_err, o_blank);
endinterface

// File: rtl/led_seg_encoder.sv
// Recovers {dp, hex} from a sampled active-low seven-segment bus after a stability filter.
module led_seg_encoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  led_seg_encoder_if.slave bus
);

  localparam int unsigned SEG_W  = 8;
  localparam int unsigned CODE_W = 5;
  localparam int unsigned HEX_W  = 4;

  localparam logic [0:0] HOLD   = 1'b0;
  localparam logic [0:0] SETTLE = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SEG_W-1:0]  sync1, sync2;
  logic [SEG_W-1:0]  cand, cand_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [0:0]        state, state_nxt;
  logic [CODE_W-1:0] code, code_nxt;
  logic              valid, valid_nxt;
  logic              err, err_nxt;
  logic              blank, blank_nxt;

  logic [SEG_W-1:0]  pat_c;
  logic [HEX_W-1:0]  hex_c;
  logic              hit_c;

  assign pat_c = ~cand;

  // Glyph lookup on the lit segments of the candidate pattern
  always_comb begin
    hit_c = 1'b1;
    hex_c = '0;
    case (pat_c[6:0])
      7'h3F: hex_c = 4'h0;
      7'h06: hex_c = 4'h1;
      7'h5B: hex_c = 4'h2;
      7'h4F: hex_c = 4'h3;
      7'h66: hex_c = 4'h4;
      7'h6D: hex_c = 4'h5;
      7'h7D: hex_c = 4'h6;
      7'h07: hex_c = 4'h7;
      7'h7F: hex_c = 4'h8;
      7'h6F: hex_c = 4'h9;
      7'h77: hex_c = 4'hA;
      7'h7C: hex_c = 4'hB;
      7'h39: hex_c = 4'hC;
      7'h5E: hex_c = 4'hD;
      7'h79: hex_c = 4'hE;
      7'h71: hex_c = 4'hF;
      default: hit_c = 1'b0;
    endcase
  end

  // Next state: any new synchronized value restarts settling and beats a pending commit
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    code_nxt  = code;
    valid_nxt = 1'b0;
    err_nxt   = err;
    blank_nxt = blank;

    if (sync2 != cand) begin
      cand_nxt  = sync2;
      cnt_nxt   = '0;
      state_nxt = SETTLE;
    end else if (state == SETTLE) begin
      if (cnt != CNT_LAST) begin
        cnt_nxt = cnt + CNT_W'(1);
      end else begin
        state_nxt = HOLD;
        if (pat_c == 8'h00) begin
          blank_nxt = 1'b1;
          err_nxt   = 1'b0;
        end else if (hit_c) begin
          code_nxt  = {pat_c[7], hex_c};
          valid_nxt = 1'b1;
          err_nxt   = 1'b0;
          blank_nxt = 1'b0;
        end else begin
          err_nxt   = 1'b1;
          blank_nxt = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 8'hFF;
      sync2 <= 8'hFF;
      cand  <= 8'hFF;
      cnt   <= '0;
      state <= HOLD;
      code  <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
      blank <= 1'b1;
    end else begin
      sync1 <= bus.i_seg_n;
      sync2 <= sync1;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
      state <= state_nxt;
      code  <= code_nxt;
      valid <= valid_nxt;
      err   <= err_nxt;
      blank <= blank_nxt;
    end
  end

  assign bus.o_code  = code;
  assign bus.o_valid = valid;
  assign bus.o_err   = err;
  assign bus.o_blank = blank;

endmodule

// File: tb/tb_led_seg_encoder.sv
// Bench for led_seg_encoder: reference model on run lengths of the synchronized input,
// vector table, legal sweep, random patterns and a STABLE_CYCLES=1 latency instance.
module tb_led_seg_encoder;

  localparam int S = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_seg_encoder_if bus ();
  led_seg_encoder_if bus1 ();

  led_seg_encoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  led_seg_encoder #(.STABLE_CYCLES(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int checks = 0;
  int errors = 0;

  // Reference model: a pattern commits when its run at the synchronizer output reaches S+1 samples
  logic [7:0] hist [$];
  logic [7:0] run_val;
  int         run_len;
  logic [4:0] m_code;
  logic       m_valid, m_err, m_blank;

  typedef struct {
    logic [7:0] seg_n;
    int         hold;
    int         n_valid;
    logic [4:0] code;
    logic       err;
    logic       blank;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    run_val = 8'hFF;
    run_len = S + 1;
    m_code  = 5'h00;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_blank = 1'b1;
  endtask

  task automatic model_edge(input logic [7:0] v);
    logic [7:0] s;
    logic [7:0] pat;
    int idx;
    s = (hist.size() >= 2) ? hist[hist.size()-2] : 8'hFF;
    hist.push_back(v);
    if (hist.size() > 2) void'(hist.pop_front());
    m_valid = 1'b0;
    if (s != run_val) begin
      run_val = s;
      run_len = 1;
    end else if (run_len <= S) begin
      run_len++;
      if (run_len == S + 1) begin
        pat = ~run_val;
        if (pat == 8'h00) begin
          m_blank = 1'b1;
          m_err   = 1'b0;
        end else begin
          idx = -1;
          for (int j = 0; j < 16; j++) if (glyph[j] == pat[6:0]) idx = j;
          if (idx >= 0) begin
            m_code  = {pat[7], 4'(idx)};
            m_valid = 1'b1;
            m_err   = 1'b0;
            m_blank = 1'b0;
          end else begin
            m_err   = 1'b1;
            m_blank = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic cycle(input logic [7:0] v);
    bus.i_seg_n = v;
    @(posedge clk);
    model_edge(v);
    @(negedge clk);
    check("code",  bus.o_code,  m_code);
    check("valid", bus.o_valid, m_valid);
    check("err",   bus.o_err,   m_err);
    check("blank", bus.o_blank, m_blank);
  endtask

  task automatic apply(input logic [7:0] v, input int hold,
                       output int nv, output logic [4:0] vc, output int fk);
    nv = 0;
    vc = bus.o_code;
    fk = 0;
    for (int i = 1; i <= hold; i++) begin
      cycle(v);
      if (bus.o_valid) begin
        nv++;
        vc = bus.o_code;
        if (fk == 0) fk = i;
      end
    end
  endtask

  task automatic cycle1(input logic [7:0] v, input int k, inout int nv, inout int fk,
                        inout logic [4:0] vc);
    bus1.i_seg_n = v;
    @(posedge clk);
    @(negedge clk);
    if (bus1.o_valid) begin
      nv++;
      vc = bus1.o_code;
      if (fk == 0) fk = k;
    end
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_code"},  bus.o_code,  0);
    check({tag, "_valid"}, bus.o_valid, 0);
    check({tag, "_err"},   bus.o_err,   0);
    check({tag, "_blank"}, bus.o_blank, 1);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, fk, nv1, fk1, bad1;
    logic [4:0] vc, vc1, kk;
    logic [7:0] v;

    tbl[0]  = '{8'hF9, 10, 1, 5'h01, 1'b0, 1'b0};
    tbl[1]  = '{8'hA4,  3, 0, 5'h01, 1'b0, 1'b0};
    tbl[2]  = '{8'hF9, 10, 1, 5'h01, 1'b0, 1'b0};
    tbl[3]  = '{8'hFE, 10, 0, 5'h01, 1'b1, 1'b0};
    tbl[4]  = '{8'hFF, 10, 0, 5'h01, 1'b0, 1'b1};
    tbl[5]  = '{8'hC0, 10, 1, 5'h00, 1'b0, 1'b0};
    tbl[6]  = '{8'hB0,  8, 1, 5'h03, 1'b0, 1'b0};
    tbl[7]  = '{8'h99,  8, 1, 5'h04, 1'b0, 1'b0};
    tbl[8]  = '{8'hB0,  8, 1, 5'h03, 1'b0, 1'b0};
    tbl[9]  = '{8'h7F, 10, 0, 5'h03, 1'b1, 1'b0};
    tbl[10] = '{8'h08, 10, 1, 5'h1A, 1'b0, 1'b0};

    rst = 1'b1;
    bus.i_seg_n  = 8'hFF;
    bus1.i_seg_n = 8'hFF;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_code",  bus.o_code,  0);
    check("rst_valid", bus.o_valid, 0);
    check("rst_err",   bus.o_err,   0);
    check("rst_blank", bus.o_blank, 1);
    rst = 1'b0;

    // Idle input after release: nothing may happen
    repeat (4) cycle(8'hFF);

    // Reset while settling on 8'h00, then a fresh change at release
    repeat (3) cycle(8'h00);
    async_reset_check("rst_settle");
    apply(8'h00, 10, nv, vc, fk);
    check("rel_first_edge", fk, 7);
    check("rel_nvalid", nv, 1);
    check("rel_code", vc, 5'h18);

    // Legal sweep over all 32 codes
    for (int k = 0; k < 32; k++) begin
      kk = 5'(k);
      v = ~{kk[4], glyph[kk[3:0]]};
      apply(v, 10, nv, vc, fk);
      check("sweep_nvalid", nv, 1);
      check("sweep_code", vc, k);
      check("sweep_edge", fk, 7);
    end

    // Vector table: glitch, illegal, blank, dp-only and same-code re-commit
    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].seg_n, tbl[i].hold, nv, vc, fk);
      check("tbl_nvalid", nv, tbl[i].n_valid);
      check("tbl_code",   bus.o_code,  tbl[i].code);
      check("tbl_err",    bus.o_err,   tbl[i].err);
      check("tbl_blank",  bus.o_blank, tbl[i].blank);
    end

    // Reset landing on the o_valid cycle
    nv = 0;
    for (int i = 0; i < 10 && nv == 0; i++) begin
      cycle(8'hF9);
      if (bus.o_valid) nv = 1;
    end
    check("pre_valid_seen", nv, 1);
    async_reset_check("rst_valid");
    apply(8'hF9, 10, nv, vc, fk);
    check("post_rst_nvalid", nv, 1);
    check("post_rst_code", vc, 5'h01);

    // Random patterns with random hold times against the model
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0, 1: v = ~{1'($urandom_range(0, 1)), glyph[$urandom_range(0, 15)]};
        2:    v = 8'hFF;
        default: v = 8'($urandom);
      endcase
      apply(v, $urandom_range(1, 9), nv, vc, fk);
    end

    // STABLE_CYCLES=1 instance: latency and a one-cycle pattern that must not commit
    nv1 = 0; fk1 = 0; vc1 = 5'h00;
    for (int k = 1; k <= 6; k++) cycle1(8'hF9, k, nv1, fk1, vc1);
    check("s1_first_edge", fk1, 4);
    check("s1_nvalid", nv1, 1);
    check("s1_code", vc1, 5'h01);

    nv1 = 0; fk1 = 0; vc1 = 5'h00; bad1 = 0;
    cycle1(8'hA4, 1, nv1, fk1, vc1);
    for (int k = 2; k <= 9; k++) begin
      cycle1(8'hB0, k, nv1, fk1, vc1);
      if (bus1.o_valid && bus1.o_code == 5'h02) bad1++;
    end
    check("s1_glitch_commits", bad1, 0);
    check("s1_next_nvalid", nv1, 1);
    check("s1_next_edge", fk1, 5);
    check("s1_next_code", vc1, 5'h03);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
